// File: rtl/rv32i_types.sv
// rv32i_types: shared completion-bus result type and requester index bases
package rv32i_types;
  typedef struct packed {
    logic [3:0]  tag;
    logic        rdy;
    logic [31:0] data;
  } sal_t;
  localparam int ALU_BASE = 0;
  localparam int BR_BASE  = 8;
  localparam int LSQ_BASE = 11;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request searching cyclically from ptr
module rr_priority_picker #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    any = |req;
    // Walk offsets high to low so the nearest index to ptr is assigned last
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin completion bus arbiter with one registered output slot
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ  = 12,
  parameter int ROB_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  input  sal_t               req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ack,
  input  logic               cdb_ready,
  output logic               cdb_valid,
  output sal_t               cdb_out
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] ptr, winner;
  logic [NUM_REQ-1:0] gnt;
  logic any, load_en, grant;
  sal_t win;
  rr_priority_picker #(.N(NUM_REQ), .W(PW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(winner),
    .any(any)
  );
  assign load_en = !cdb_valid || cdb_ready;
  assign grant   = load_en && !flush && !rst && any;
  assign req_ack = grant ? gnt : '0;
  always_comb begin
    win = req_data[winner];
    win.rdy = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_out   <= '0;
    end else if (load_en) begin
      cdb_valid <= any;
      cdb_out   <= any ? win : '0;
      ptr       <= any ? (winner == PW'(NUM_REQ - 1) ? '0 : winner + PW'(1)) : ptr;
    end
  end
  always_ff @(posedge clk)
    if (grant) assert (int'(win.tag) < ROB_SIZE) else $error("cdb_arbiter: granted tag %0d out of ROB range", win.tag);
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 12, giving the number of completion requesters (8 ALU RS + 3 BR RS + 1 LSQ).
REQ-002 The block SHALL take parameter ROB_SIZE, default 8, giving the number of ROB entries; tags at or above this value are illegal.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: squash of in-flight completion.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: requester i holds a completed result.
REQ-007 The block SHALL have port req_data, input, sal_t[NUM_REQ]: tag[3:0], rdy, data[31:0] per requester.
REQ-008 The block SHALL have port req_ack, output, NUM_REQ bits: one-hot grant; requester i retires its result this cycle.
REQ-009 The block SHALL have port cdb_ready, input, 1 bit: the ROB/broadcast consumer accepts cdb_out this cycle.
REQ-010 The block SHALL have port cdb_valid, output, 1 bit: cdb_out holds a result.
REQ-011 The block SHALL have port cdb_out, output, sal_t: the registered winning result.

Function
REQ-012 The block SHALL keep a round-robin pointer ptr of $clog2(NUM_REQ) bits; reset value 0.
REQ-013 The winner SHALL be the first index i with req_valid[i]=1, searching cyclically from ptr (ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1).
REQ-014 The output register SHALL be loadable when cdb_valid=0 or cdb_ready=1 (load_en).
REQ-015 A grant SHALL occur only when load_en=1, flush=0 and at least one req_valid bit is set; req_ack SHALL then be combinational one-hot on the winner, and all zeros otherwise.
REQ-016 On a grant, the next edge SHALL set cdb_out to req_data[winner] with rdy forced to 1, set cdb_valid to 1, and set ptr to (winner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-017 When load_en=1 and there is no grant, the next edge SHALL clear cdb_valid to 0 and cdb_out to all zeros.
REQ-018 When load_en=0 (cdb_valid=1, cdb_ready=0), cdb_out, cdb_valid and ptr SHALL hold and req_ack SHALL be 0.
REQ-019 Latency SHALL be exactly 1 cycle from req_ack to cdb_valid.
REQ-020 Throughput SHALL be 1 result per cycle while cdb_ready=1 and any request is pending.
REQ-021 ptr SHALL be unchanged in any cycle without a grant.
REQ-022 Flush SHALL take priority over grant: req_ack=0, and the next edge SHALL give cdb_valid=0, cdb_out=0, ptr=0.
REQ-023 A requester whose req_valid drops before ack SHALL simply lose arbitration, with no state kept for it.
REQ-024 A grant with tag >= ROB_SIZE SHALL be a simulation assertion error; the RTL SHALL pass it through unchanged.
REQ-025 The block SHALL hold no other state; with NUM_REQ=1 it SHALL degenerate to a one-entry pipeline register.

Reset
REQ-026 While rst=1 at a clk edge, ptr=0, cdb_valid=0 and cdb_out=0; req_ack SHALL be 0 during any cycle with rst=1.
REQ-027 Reset mid-transfer SHALL discard a held cdb_out without delivery, and requesters SHALL not see an ack.
REQ-028 rst SHALL dominate flush, which SHALL dominate grant.

Structure
REQ-029 sal_t SHALL reside in the shared package rv32i_types; requester index bases (ALU 0-7, BR 8-10, LSQ 11) SHALL be localparams there.
REQ-030 The cyclic search SHALL be one combinational sub-module, rr_priority_picker (inputs: request vector, ptr; outputs: one-hot grant, winner index, any).
REQ-031 The only sequential elements SHALL be ptr, cdb_valid and cdb_out, in one clocked process.

Verification
REQ-032 Reset, then req_valid=0 with cdb_ready=1 for 5 cycles -> cdb_valid=0, req_ack=0, ptr=0 throughout.
REQ-033 req_valid=all ones held, cdb_ready=1 -> acks in order 0,1,...,11,0,...; cdb_valid=1 every cycle from cycle 2; ptr wraps 11->0.
REQ-034 req_valid[3] with tag 5 and data 0xDEADBEEF, cdb_ready=0 for 3 cycles -> single ack at cycle 1; cdb_out={5,1,0xDEADBEEF} stable; no acks until cdb_ready=1.
REQ-035 ptr=4 and req_valid bits 2 and 9 set -> ack[9] first, ptr=10, then ack[2], ptr=3.
REQ-036 flush=1 while cdb_valid=1 and req_valid[0]=1 -> req_ack=0 that cycle; next cycle cdb_valid=0 and ptr=0.
REQ-037 rst=1 while cdb_valid=1 and cdb_ready=0 -> next cycle cdb_valid=0 and cdb_out=0, with no ack in the rst cycle.
